// File: rtl/z_stream_monitor.sv
// Watches the upstream Z stream, matches a PAT_W-bit pattern, counts ones and hits,
// and reports each hit over a valid/ack handshake together with the source state.
module z_stream_monitor #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             Z_in,
  input  logic [2:0]       Q_in,
  input  logic [PAT_W-1:0] Pattern,
  input  logic             Arm,
  input  logic             Ack,
  output logic [PAT_W-1:0] Window,
  output logic             Hit,
  output logic [2:0]       Hit_State,
  output logic [CNT_W-1:0] Hit_Count,
  output logic [CNT_W-1:0] Ones_Count,
  output logic             Overrun
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  state_t            state, state_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic [PAT_W-1:0]  win_nxt;
  logic              match;
  logic              arm_clear, hit_set, hit_clr, hit_inc, cap_state, ovr_set;

  assign win_nxt  = {Window[PAT_W-2:0], Z_in};
  assign fill_nxt = (fill == FILL_MAX) ? fill : fill + 1'b1;
  // fill guards against matching the zero-padded window right after reset
  assign match    = En && (fill_nxt == FILL_MAX) && (win_nxt == Pattern);

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm_clear = 1'b0;
    hit_set   = 1'b0;
    hit_clr   = 1'b0;
    hit_inc   = 1'b0;
    cap_state = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (Arm) begin
          state_nxt = ARMED;
          arm_clear = 1'b1;
        end
      end
      ARMED: begin
        if (!Arm) begin
          state_nxt = IDLE;
        end else if (match) begin
          state_nxt = HOLD;
          hit_set   = 1'b1;
          cap_state = 1'b1;
          hit_inc   = 1'b1;
        end
      end
      HOLD: begin
        if (Ack) begin
          // an acked hit immediately replaced by a new one is not an overrun
          if (match && Arm) begin
            cap_state = 1'b1;
            hit_inc   = 1'b1;
          end else begin
            hit_clr   = 1'b1;
            state_nxt = Arm ? ARMED : IDLE;
          end
        end else if (match) begin
          ovr_set = 1'b1;
          hit_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Window     <= '0;
      fill       <= '0;
      Hit        <= 1'b0;
      Hit_State  <= '0;
      Hit_Count  <= '0;
      Ones_Count <= '0;
      Overrun    <= 1'b0;
    end else begin
      if (En) begin
        Window <= win_nxt;
        fill   <= fill_nxt;
      end
      if (hit_set)      Hit <= 1'b1;
      else if (hit_clr) Hit <= 1'b0;
      if (cap_state) Hit_State <= Q_in;
      if (arm_clear) begin
        Hit_Count  <= '0;
        Overrun    <= 1'b0;
        Ones_Count <= CNT_W'(En && Z_in);
      end else begin
        if (hit_inc && (Hit_Count != '1)) Hit_Count <= Hit_Count + 1'b1;
        if (ovr_set) Overrun <= 1'b1;
        if (En && Z_in && (Ones_Count != '1)) Ones_Count <= Ones_Count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_z_stream_monitor.sv
// Scoreboarded bench: directed scenarios then random traffic, two counter widths in parallel.
module tb_z_stream_monitor;
  localparam int PW = 4;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Rst_n, En, Z_in, Arm, Ack;
  logic [2:0]    Q_in;
  logic [PW-1:0] Pattern;

  logic [PW-1:0] a_win, b_win;
  logic          a_hit, b_hit, a_ovr, b_ovr;
  logic [2:0]    a_hs, b_hs;
  logic [7:0]    a_hc, a_ones;
  logic [2:0]    b_hc, b_ones;

  z_stream_monitor #(.PAT_W(PW), .CNT_W(8)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Z_in(Z_in), .Q_in(Q_in), .Pattern(Pattern),
    .Arm(Arm), .Ack(Ack), .Window(a_win), .Hit(a_hit), .Hit_State(a_hs),
    .Hit_Count(a_hc), .Ones_Count(a_ones), .Overrun(a_ovr));

  z_stream_monitor #(.PAT_W(PW), .CNT_W(3)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Z_in(Z_in), .Q_in(Q_in), .Pattern(Pattern),
    .Arm(Arm), .Ack(Ack), .Window(b_win), .Hit(b_hit), .Hit_State(b_hs),
    .Hit_Count(b_hc), .Ones_Count(b_ones), .Overrun(b_ovr));

  int total = 0;
  int bad   = 0;

  // reference: mode 0 = idle, 1 = armed, 2 = holding a hit; counts kept unbounded
  int       m_mode, m_hc, m_ones;
  bit       m_hit, m_ovr;
  bit [2:0] m_hs;
  bit       zh[$];

  typedef struct {
    logic [PW-1:0] win;
    logic          hit;
    logic [2:0]    hs;
    int            hc;
    int            ones;
    logic          ovr;
  } exp_t;
  exp_t sb[$];

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic z, input logic [2:0] q,
                      input logic arm, input logic ack);
    bit   match;
    exp_t e;
    Rst_n = rst; En = en; Z_in = z; Q_in = q; Arm = arm; Ack = ack;
    if (!rst) begin
      m_mode = 0; m_hc = 0; m_ones = 0; m_hit = 0; m_ovr = 0; m_hs = '0;
      zh.delete();
    end else begin
      match = 1'b0;
      if (en) begin
        zh.push_back(z);
        if (zh.size() > PW) void'(zh.pop_front());
        if (zh.size() == PW) begin
          match = 1'b1;
          for (int i = 0; i < PW; i++)
            if (zh[PW-1-i] != Pattern[i]) match = 1'b0;
        end
      end
      case (m_mode)
        0: if (arm) begin m_mode = 1; m_hc = 0; m_ones = 0; m_ovr = 0; end
        1: begin
          if (!arm) m_mode = 0;
          else if (match) begin m_mode = 2; m_hit = 1; m_hs = q; m_hc++; end
        end
        default: begin
          if (ack) begin
            if (match && arm) begin m_hs = q; m_hc++; end
            else begin m_hit = 0; m_mode = arm ? 1 : 0; end
          end else if (match) begin
            m_ovr = 1; m_hc++;
          end
        end
      endcase
      if (en && z) m_ones++;
    end
    e.win = '0;
    for (int i = 0; i < PW; i++)
      if (i < zh.size()) e.win[i] = zh[zh.size()-1-i];
    e.hit = m_hit; e.hs = m_hs; e.hc = m_hc; e.ones = m_ones; e.ovr = m_ovr;
    sb.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mon_win",    a_win,  e.win);
      chk("mon_hit",    a_hit,  e.hit);
      chk("mon_state",  a_hs,   e.hs);
      chk("mon_ovr",    a_ovr,  e.ovr);
      chk("mon_hc8",    a_hc,   sat(e.hc, 8));
      chk("mon_ones8",  a_ones, sat(e.ones, 8));
      chk("mon_b_win",  b_win,  e.win);
      chk("mon_b_hit",  b_hit,  e.hit);
      chk("mon_b_st",   b_hs,   e.hs);
      chk("mon_b_ovr",  b_ovr,  e.ovr);
      chk("mon_hc3",    b_hc,   sat(e.hc, 3));
      chk("mon_ones3",  b_ones, sat(e.ones, 3));
    end
  end

  initial begin
    Pattern = 4'b1011;
    // reset with active inputs
    repeat (3) step(0, 1, 1, 3'b111, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_hit", a_hit, 0);
    chk("rst_win", a_win, 0);
    chk("rst_ones", a_ones, 0);
    chk("rst_hc", a_hc, 0);
    chk("rst_ovr", a_ovr, 0);

    // basic hit on 1,0,1,1
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 3'b101, 1, 0);
    chk("basic_win", a_win, 4'b1011);
    chk("basic_hit", a_hit, 1);
    chk("basic_state", a_hs, 3'b101);
    chk("basic_hc", a_hc, 1);
    chk("basic_ones", a_ones, 3);
    step(1, 0, 0, 0, 1, 1);
    chk("ack_hit", a_hit, 0);

    // overlapping pattern, ack coinciding with a new match
    step(1, 0, 0, 0, 0, 0);
    Pattern = 4'b1010;
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 3'b011, 1, 0);
    chk("ovl_hit1", a_hit, 1);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 3'b110, 1, 1);
    chk("sim_hit", a_hit, 1);
    chk("sim_hc", a_hc, 2);
    chk("sim_ovr", a_ovr, 0);
    chk("sim_state", a_hs, 3'b110);

    // overrun while unacked
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 3'b001, 1, 0);
    chk("ovr_set", a_ovr, 1);
    chk("ovr_hc", a_hc, 3);
    chk("ovr_state", a_hs, 3'b110);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("rearm_ovr", a_ovr, 0);
    chk("rearm_hc", a_hc, 0);
    chk("rearm_ones", a_ones, 0);

    // enable gating
    for (int i = 0; i < 5; i++) step(1, 0, i[0], 3'b010, 1, 0);
    chk("gate_win", a_win, 4'b1010);
    chk("gate_ones", a_ones, 0);

    // reset in the middle of a held hit
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 3'b111, 1, 0);
    chk("hold_hit", a_hit, 1);
    step(0, 1, 1, 3'b101, 1, 1);
    chk("mrst_hit", a_hit, 0);
    chk("mrst_hc", a_hc, 0);
    chk("mrst_win", a_win, 0);

    // partial fill must not match the zero-padded window
    Pattern = 4'b0101;
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("fill_win", a_win, 4'b0101);
    chk("fill_hit", a_hit, 0);

    // disarmed: matches ignored, ones still counted
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("disarm_hit", a_hit, 0);
    chk("disarm_ones", a_ones, 5);

    // saturation
    Pattern = 4'b1111;
    step(1, 0, 0, 0, 1, 0);
    repeat (10) step(1, 1, 1, 3'b100, 1, 0);
    chk("sat_ones3", b_ones, 7);
    chk("sat_ones8", a_ones, 10);
    chk("sat_hc3", b_hc, 7);
    repeat (5) step(1, 1, 1, 3'b011, 1, 1);
    chk("sat_hc3b", b_hc, 7);
    chk("sat_hc8", a_hc, 13);
    chk("sat_ones3b", b_ones, 7);

    // random traffic
    for (int seg = 0; seg < 8; seg++) begin
      if ($urandom_range(0, 2) == 0) step(0, 1, 1, 0, 1, 1);
      step(1, 0, 0, 0, 0, 1);
      Pattern = PW'($urandom);
      for (int c = 0; c < 300; c++)
        step(1, $urandom_range(0, 4) != 0, 1'($urandom), 3'($urandom),
             $urandom_range(0, 24) != 0, $urandom_range(0, 9) < 3);
    end

    repeat (2) @(negedge Clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
